cnt_down_timer: RTL
===================

// Module: cnt_down_timer
// PURPOSE
//  Loadable down-counting timer, the countdown counterpart of the free-running/modulo up-counters.
//  Accepts a start value over a valid/ready load handshake and decrements once per prescaled tick.
//  Signals expiry with a one-cycle DONE pulse; optional auto-reload gives a periodic tick source.
//  Feeds timeouts and periodic strobes to sequencing logic in the same clock domain.
// PARAMETERS
//  WIDTH     8  counter / load value width in bits (>=2)
//  PRESCALE  1  CLK cycles per count tick (>=1; 1 = decrement every cycle)
// PORTS
//  CLK          in   1      system clock, all logic on rising edge
//  RST          in   1      synchronous reset, active-high
//  LOAD_VALID   in   1      load request; LOAD_VAL/AUTO_RELOAD valid while high
//  LOAD_READY   out  1      timer can accept a load (combinational: IDLE && !ABORT)
//  LOAD_VAL     in   WIDTH  start count, captured on accept
//  AUTO_RELOAD  in   1      captured on accept; 1 = reload LOAD_VAL on expiry and keep running
//  PAUSE        in   1      freeze prescaler and CNT while high (RUN/HOLD only)
//  ABORT        in   1      cancel current run, return to IDLE
//  CNT          out  WIDTH  current count (registered)
//  BUSY         out  1      1 while in RUN or HOLD (registered)
//  DONE         out  1      one-cycle expiry pulse (registered)
// BEHAVIOUR
//  - Reset: state IDLE, CNT=0, BUSY=0, DONE=0, prescaler=0, reload reg=0, auto flag=0. RST beats everything.
//  - States: IDLE, RUN, HOLD. BUSY = (state != IDLE). DONE defaults low every cycle.
//  - Accept = LOAD_VALID && LOAD_READY at an edge: CNT<=LOAD_VAL, reload<=LOAD_VAL,
//    auto<=AUTO_RELOAD, prescaler<=0, state<=RUN.
//    Exception LOAD_VAL==0: stay IDLE, CNT=0, DONE=1 next cycle, auto ignored.
//  - Tick: in RUN when prescaler==PRESCALE-1 and !PAUSE. The prescaler counts 0..PRESCALE-1 and wraps
//    to 0 on tick; with PRESCALE=1 every RUN cycle is a tick.
//  - On tick with CNT>1: CNT<=CNT-1.
//  - On tick with CNT==1: DONE<=1. If auto: CNT<=reload, stay RUN. Else: CNT<=0, state<=IDLE.
//  - Latency: load N accepted at edge t0 -> DONE high in the cycle after edge t0+N*PRESCALE.
//    With auto, the period is N*PRESCALE cycles.
//  - PAUSE high in RUN: next state HOLD. Prescaler and CNT are frozen; no tick that edge, even if it
//    would be the final one. PAUSE low in HOLD: back to RUN, prescaler resumes from its held value.
//    PAUSE is ignored in IDLE.
//  - ABORT (any state): state<=IDLE, CNT<=0, prescaler<=0, DONE stays 0.
//    ABORT+LOAD_VALID in the same cycle: no accept. ABORT on the final-tick edge: no DONE.
//  - LOAD_VALID while BUSY: not accepted (LOAD_READY=0). The requester holds it until ready.
//    No queuing, no restart of a running count.
//  - Mid-run RST: next edge all reset values, no DONE.
//  - CNT never underflows/wraps. Max load 2^WIDTH-1 is legal.
// TESTING
//  1 PRESCALE=1, load 5, auto=0 -> CNT 5,4,3,2,1,0 on successive cycles; DONE one pulse coincident
//    with CNT=0; BUSY falls same edge; LOAD_READY=1 after.
//  2 PRESCALE=3, load 2, auto=1, run 20 cycles -> DONE every 6 cycles, CNT reloads 2, BUSY stays 1.
//  3 Load 4, PAUSE high 5 cycles after the 2nd tick -> CNT frozen at 2 during pause;
//    DONE delayed by exactly 5 cycles (total 9).
//  4 Load 0 -> DONE pulse the next cycle, BUSY never high. Load 255 with WIDTH=8 -> DONE after 255 cycles.
//  5 ABORT on the CNT==1 edge -> CNT=0, IDLE, no DONE. ABORT+LOAD_VALID together -> not accepted.
//  6 RST asserted mid-RUN (CNT=3) -> next cycle CNT=0, BUSY=0, DONE=0. LOAD_VALID while BUSY -> ignored.

Source files
------------

// File: rtl/cnt_down_timer.sv
// Loadable down-counter: decrements once per PRESCALE-cycle tick and pulses DONE one cycle after expiry.
// Load accepted only when idle and not aborting; a busy timer holds off LOAD_VALID via LOAD_READY=0.
module cnt_down_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             AUTO_RELOAD,
  input  logic             PAUSE,
  input  logic             ABORT,
  output logic [WIDTH-1:0] CNT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   presc, presc_n;
  logic [WIDTH-1:0] cnt_n;
  logic [WIDTH-1:0] reload, reload_n;
  logic            auto_rl, auto_rl_n;
  logic            done_n;
  logic            accept;

  assign LOAD_READY = (state == ST_IDLE) && !ABORT;
  assign accept     = LOAD_VALID && LOAD_READY;

  always_comb begin
    state_n   = state;
    presc_n   = presc;
    cnt_n     = CNT;
    reload_n  = reload;
    auto_rl_n = auto_rl;
    done_n    = 1'b0;
    if (ABORT) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      presc_n = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (LOAD_VAL == '0) begin
              done_n = 1'b1;
              cnt_n  = '0;
            end else begin
              cnt_n     = LOAD_VAL;
              reload_n  = LOAD_VAL;
              auto_rl_n = AUTO_RELOAD;
              presc_n   = '0;
              state_n   = ST_RUN;
            end
          end
        end
        // The edge that releases PAUSE already counts, so a pause costs exactly its own length.
        ST_RUN, ST_HOLD: begin
          if (PAUSE) begin
            state_n = ST_HOLD;
          end else begin
            state_n = ST_RUN;
            if (presc == PRESC_LAST) begin
              presc_n = '0;
              if (CNT > WIDTH'(1)) begin
                cnt_n = CNT - WIDTH'(1);
              end else begin
                done_n = 1'b1;
                if (auto_rl) begin
                  cnt_n = reload;
                end else begin
                  cnt_n   = '0;
                  state_n = ST_IDLE;
                end
              end
            end else begin
              presc_n = presc + PW'(1);
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          presc_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      presc   <= '0;
      CNT     <= '0;
      reload  <= '0;
      auto_rl <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      CNT     <= cnt_n;
      reload  <= reload_n;
      auto_rl <= auto_rl_n;
      BUSY    <= (state_n != ST_IDLE);
      DONE    <= done_n;
    end
  end

endmodule
